// File: rtl/pad_serial_bridge.sv
// Pad-side serial bridge: deserialises threshold frames from the pads, serialises
// core voltage words back out, and produces a synchronised core reset.
module pad_serial_bridge #(
  parameter int THRES_W     = 6,
  parameter int V_W         = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sdiI,
  input  logic               sframeI,
  output logic [THRES_W-1:0] thres,
  output logic               thres_valid,
  input  logic [V_W-1:0]     v,
  input  logic               v_valid,
  output logic               sdoO,
  output logic               sdo_frameO,
  output logic               busy,
  input  logic               clr_err,
  output logic               frame_err,
  output logic               ovf,
  output logic               rst_n_sync
);

  localparam int CNT_W = $clog2(THRES_W + 1);
  localparam int BIT_W = $clog2(V_W);

  typedef enum logic [1:0] {DES_IDLE, DES_SHIFT, DES_DRAIN} des_state_e;
  typedef enum logic [1:0] {SER_IDLE, SER_SEND, SER_GAP}    ser_state_e;

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state is only ever written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_n_sync = sync_q[SYNC_STAGES-1];

  // ---------------- threshold deserialiser ----------------
  logic               r_sdi_q, r_sframe_q;
  des_state_e         des_state_q, des_state_d;
  logic [THRES_W-1:0] des_sh_q, des_sh_d;
  logic [CNT_W-1:0]   des_cnt_q, des_cnt_d;
  logic [THRES_W-1:0] thres_q, thres_d;
  logic               thres_valid_q, thres_valid_d;
  logic               frame_err_q, frame_err_d, ferr_set;

  // NOTE: every signal assigned below gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    des_state_d   = des_state_q;
    des_sh_d      = des_sh_q;
    des_cnt_d     = des_cnt_q;
    thres_d       = thres_q;
    thres_valid_d = 1'b0;
    ferr_set      = 1'b0;
    case (des_state_q)
      DES_IDLE: begin
        if (r_sframe_q) begin
          des_sh_d    = {des_sh_q[THRES_W-2:0], r_sdi_q};
          des_cnt_d   = CNT_W'(1);
          des_state_d = DES_SHIFT;
        end
      end
      DES_SHIFT: begin
        if (r_sframe_q) begin
          if (des_cnt_q == CNT_W'(THRES_W)) begin
            ferr_set    = 1'b1;
            des_state_d = DES_DRAIN;
          end else begin
            des_sh_d  = {des_sh_q[THRES_W-2:0], r_sdi_q};
            des_cnt_d = des_cnt_q + CNT_W'(1);
          end
        end else begin
          if (des_cnt_q == CNT_W'(THRES_W)) begin
            thres_d       = des_sh_q;
            thres_valid_d = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
          des_state_d = DES_IDLE;
        end
      end
      DES_DRAIN: begin
        if (!r_sframe_q) des_state_d = DES_IDLE;
      end
      default: des_state_d = DES_IDLE;
    endcase
    // A set in the same cycle as a clear wins.
    frame_err_d = ferr_set | (frame_err_q & ~clr_err);
  end

  // ---------------- voltage serialiser ----------------
  ser_state_e     ser_state_q, ser_state_d;
  logic [V_W-1:0] ser_sh_q, ser_sh_d;
  logic [BIT_W-1:0] ser_cnt_q, ser_cnt_d;
  logic [V_W-1:0] hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic           ovf_q, ovf_d, ovf_set;
  logic           sdo_q, sdo_frame_q;

  always_comb begin
    ser_state_d = ser_state_q;
    ser_sh_d    = ser_sh_q;
    ser_cnt_d   = ser_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovf_set     = 1'b0;
    case (ser_state_q)
      SER_IDLE: begin
        if (v_valid) begin
          ser_sh_d    = v;
          ser_cnt_d   = '0;
          ser_state_d = SER_SEND;
        end
      end
      SER_SEND: begin
        if (ser_cnt_q == BIT_W'(V_W - 1)) begin
          ser_state_d = SER_GAP;
        end else begin
          ser_sh_d  = {ser_sh_q[V_W-2:0], 1'b0};
          ser_cnt_d = ser_cnt_q + BIT_W'(1);
        end
        if (v_valid) begin
          if (hold_full_q) begin
            ovf_set = 1'b1;
          end else begin
            hold_d      = v;
            hold_full_d = 1'b1;
          end
        end
      end
      SER_GAP: begin
        if (hold_full_q) begin
          ser_sh_d    = hold_q;
          hold_full_d = 1'b0;
          ser_cnt_d   = '0;
          ser_state_d = SER_SEND;
          ovf_set     = v_valid;
        end else if (v_valid) begin
          // An empty holding buffer would be unloaded at this same edge, so the
          // word goes straight into the shift register.
          ser_sh_d    = v;
          ser_cnt_d   = '0;
          ser_state_d = SER_SEND;
        end else begin
          ser_state_d = SER_IDLE;
        end
      end
      default: ser_state_d = SER_IDLE;
    endcase
    ovf_d = ovf_set | (ovf_q & ~clr_err);
  end

  // NOTE: data registers are reset along with control so an aborted frame can
  // never leave stale bits that reappear on the pads after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sdi_q       <= 1'b0;
      r_sframe_q    <= 1'b0;
      des_state_q   <= DES_IDLE;
      des_sh_q      <= '0;
      des_cnt_q     <= '0;
      thres_q       <= '0;
      thres_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      ser_state_q   <= SER_IDLE;
      ser_sh_q      <= '0;
      ser_cnt_q     <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      ovf_q         <= 1'b0;
      sdo_q         <= 1'b0;
      sdo_frame_q   <= 1'b0;
    end else begin
      r_sdi_q       <= sdiI;
      r_sframe_q    <= sframeI;
      des_state_q   <= des_state_d;
      des_sh_q      <= des_sh_d;
      des_cnt_q     <= des_cnt_d;
      thres_q       <= thres_d;
      thres_valid_q <= thres_valid_d;
      frame_err_q   <= frame_err_d;
      ser_state_q   <= ser_state_d;
      ser_sh_q      <= ser_sh_d;
      ser_cnt_q     <= ser_cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      ovf_q         <= ovf_d;
      sdo_frame_q   <= (ser_state_d == SER_SEND);
      sdo_q         <= (ser_state_d == SER_SEND) & ser_sh_d[V_W-1];
    end
  end

  assign thres       = thres_q;
  assign thres_valid = thres_valid_q;
  assign frame_err   = frame_err_q;
  assign ovf         = ovf_q;
  assign sdoO        = sdo_q;
  assign sdo_frameO  = sdo_frame_q;
  assign busy        = (ser_state_q != SER_IDLE) | hold_full_q;

endmodule

// File: tb/tb_pad_serial_bridge.sv
// Testbench for pad_serial_bridge: directed vectors and sequences plus randomized
// traffic compared every cycle against a transaction-level timing model.
module tb_pad_serial_bridge;

  localparam int W  = 6;
  localparam int VW = 6;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n, sdi, sframe, vv, clr;
  logic [VW-1:0] vin;
  logic [W-1:0]  thres;
  logic          thres_valid, sdo, sdo_frame, busy, frame_err, ovf, rst_n_sync;

  pad_serial_bridge #(.THRES_W(W), .V_W(VW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .sdiI(sdi), .sframeI(sframe),
    .thres(thres), .thres_valid(thres_valid), .v(vin), .v_valid(vv),
    .sdoO(sdo), .sdo_frameO(sdo_frame), .busy(busy), .clr_err(clr),
    .frame_err(frame_err), .ovf(ovf), .rst_n_sync(rst_n_sync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  int pulse_cnt = 0;

  always @(negedge clk) if (thres_valid === 1'b1) pulse_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, n, act, exp);
    end
  endtask

  // ---- reference model: pad-sample run lengths in, scheduled word slots out ----
  typedef struct { int a; int s; logic [VW-1:0] w; } word_t;
  word_t        sched[$];
  int           last_s, run, sync_cnt;
  logic [W-1:0] acc, d_word, exp_thres;
  logic         d_val, d_err, exp_tv, exp_ferr, exp_ovf;

  task automatic model_reset();
    sched.delete();
    last_s = -1000; run = 0; sync_cnt = 0;
    acc = '0; d_word = '0; exp_thres = '0;
    d_val = 1'b0; d_err = 1'b0; exp_tv = 1'b0; exp_ferr = 1'b0; exp_ovf = 1'b0;
  endtask

  // Called once per rising edge, with the inputs the DUT sampled at that edge.
  task automatic model_edge();
    logic err_now, drop;
    int   start;
    word_t e;
    // Input frames take effect one edge after their pad sample (retime flop).
    err_now = d_err;
    exp_tv  = d_val;
    if (d_val) exp_thres = d_word;
    d_val = 1'b0;
    d_err = 1'b0;
    if (sframe) begin
      run++;
      if (run <= W) acc = {acc[W-2:0], sdi};
      if (run == W + 1) d_err = 1'b1;
    end else begin
      if (run == W) begin
        d_val  = 1'b1;
        d_word = acc;
      end else if (run > 0 && run < W) begin
        d_err = 1'b1;
      end
      run = 0;
      acc = '0;
    end
    exp_ferr = err_now | (exp_ferr & ~clr);
    // Each word owns VW bit slots plus one gap slot; one word may wait behind it.
    drop = 1'b0;
    if (vv) begin
      if (last_s >= n) begin
        drop = 1'b1;
      end else begin
        start = (n >= last_s + VW + 1) ? n : last_s + VW + 1;
        e.a = n; e.s = start; e.w = vin;
        sched.push_back(e);
        last_s = start;
      end
    end
    exp_ovf = drop | (exp_ovf & ~clr);
    sync_cnt++;
  endtask

  task automatic model_compare();
    logic e_frame, e_bit, e_busy;
    int   idx;
    e_frame = 1'b0; e_bit = 1'b0; e_busy = 1'b0;
    while (sched.size() > 0 && sched[0].s + VW < n) sched.delete(0);
    foreach (sched[i]) begin
      if (n >= sched[i].s && n < sched[i].s + VW) begin
        idx     = VW - 1 - (n - sched[i].s);
        e_frame = 1'b1;
        e_bit   = sched[i].w[idx];
      end
      if (n >= sched[i].a && n <= sched[i].s + VW) e_busy = 1'b1;
    end
    check("m_thres",       32'(thres),       32'(exp_thres));
    check("m_thres_valid", 32'(thres_valid), 32'(exp_tv));
    check("m_frame_err",   32'(frame_err),   32'(exp_ferr));
    check("m_sdo_frame",   32'(sdo_frame),   32'(e_frame));
    check("m_sdo",         32'(sdo),         32'(e_bit));
    check("m_busy",        32'(busy),        32'(e_busy));
    check("m_ovf",         32'(ovf),         32'(exp_ovf));
    check("m_rst_n_sync",  32'(rst_n_sync),  32'(sync_cnt >= SS));
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    if (rst_n) model_edge();
    #1;
    model_compare();
  endtask

  task automatic drive_frame(input logic [15:0] pat, input int len);
    for (int b = 0; b < len; b++) begin
      sframe = 1'b1;
      sdi    = pat[len-1-b];
      step();
    end
    sframe = 1'b0;
    sdi    = 1'b0;
  endtask

  typedef struct {
    logic [15:0]  pat;
    int           len;
    logic         exp_valid;
    logic [W-1:0] exp_thres;
    logic         exp_err;
  } thr_vec_t;

  thr_vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           p0, rem, gap;
    logic [VW-1:0] w_a, w_b;
    logic          e_frame, e_bit;

    vecs[0] = '{16'b101101,   6, 1'b1, 6'b101101, 1'b0};
    vecs[1] = '{16'b1010,     4, 1'b0, 6'b101101, 1'b1};
    vecs[2] = '{16'b11001100, 8, 1'b0, 6'b101101, 1'b1};
    vecs[3] = '{16'b010011,   6, 1'b1, 6'b010011, 1'b0};
    vecs[4] = '{16'b1,        1, 1'b0, 6'b010011, 1'b1};
    vecs[5] = '{16'b111111,   6, 1'b1, 6'b111111, 1'b0};

    rst_n = 1'b0; sdi = 1'b0; sframe = 1'b0; vv = 1'b0; clr = 1'b0; vin = '0;
    model_reset();

    // Reset held, then released: sync output rises on the second edge.
    repeat (3) step();
    check("rst_sync_held", 32'(rst_n_sync), 32'(0));
    check("rst_thres",     32'(thres),      32'(0));
    check("rst_busy",      32'(busy),       32'(0));
    rst_n = 1'b1;
    step();
    check("sync_edge1", 32'(rst_n_sync), 32'(0));
    step();
    check("sync_edge2", 32'(rst_n_sync), 32'(1));
    check("rel_sdo_frame", 32'(sdo_frame), 32'(0));
    check("rel_ovf",       32'(ovf),       32'(0));

    // Threshold frame vectors: good, short, long, good, 1-bit, all-ones.
    for (int i = 0; i < 6; i++) begin
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_err", 32'(frame_err), 32'(0));
      p0 = pulse_cnt;
      drive_frame(vecs[i].pat, vecs[i].len);
      step();
      step();
      check("vec_valid", 32'(thres_valid), 32'(vecs[i].exp_valid));
      check("vec_thres", 32'(thres),       32'(vecs[i].exp_thres));
      check("vec_err",   32'(frame_err),   32'(vecs[i].exp_err));
      step();
      check("vec_single_pulse", 32'(thres_valid), 32'(0));
      check("vec_pulse_count",  32'(pulse_cnt - p0), 32'(vecs[i].exp_valid));
    end

    // Single voltage word.
    vin = 6'b110010;
    vv  = 1'b1;
    step();
    vv = 1'b0;
    w_a = 6'b110010;
    for (int k = 0; k < VW; k++) begin
      check("word_frame", 32'(sdo_frame), 32'(1));
      check("word_bit",   32'(sdo),       32'(w_a[VW-1-k]));
      step();
    end
    check("word_gap_frame", 32'(sdo_frame), 32'(0));
    check("word_gap_busy",  32'(busy),      32'(1));
    step();
    check("word_idle_busy", 32'(busy), 32'(0));

    // Back-to-back: 0x2A, then 0x15 held, then 0x3F dropped.
    w_a = 6'h2A;
    w_b = 6'h15;
    for (int k = 0; k < 15; k++) begin
      vv  = (k < 3);
      vin = (k == 0) ? 6'h2A : (k == 1) ? 6'h15 : 6'h3F;
      step();
      vv = 1'b0;
      e_frame = 1'b0;
      e_bit   = 1'b0;
      if (k < VW) begin
        e_frame = 1'b1;
        e_bit   = w_a[VW-1-k];
      end else if (k > VW && k <= 2 * VW) begin
        e_frame = 1'b1;
        e_bit   = w_b[VW-1-(k-VW-1)];
      end
      check("b2b_frame", 32'(sdo_frame), 32'(e_frame));
      check("b2b_bit",   32'(sdo),       32'(e_bit));
      if (k == 2)  check("b2b_ovf", 32'(ovf), 32'(1));
      if (k == 14) check("b2b_idle_busy", 32'(busy), 32'(0));
    end

    // Mid-frame reset during bit 3 of both directions.
    vin = 6'b101011;
    vv  = 1'b1;
    sframe = 1'b1;
    sdi = 1'b1;
    step();
    vv  = 1'b0;
    sdi = 1'b0;
    step();
    sdi = 1'b1;
    step();
    check("mid_frame_active", 32'(sdo_frame), 32'(1));
    rst_n = 1'b0;
    #2;
    model_reset();
    check("mid_sdo_frame", 32'(sdo_frame), 32'(0));
    check("mid_sdo",       32'(sdo),       32'(0));
    check("mid_thres",     32'(thres),     32'(0));
    check("mid_busy",      32'(busy),      32'(0));
    check("mid_ovf",       32'(ovf),       32'(0));
    check("mid_sync",      32'(rst_n_sync), 32'(0));
    sframe = 1'b0;
    sdi    = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    vin = 6'b100111;
    vv  = 1'b1;
    step();
    vv = 1'b0;
    drive_frame(16'b011010, 6);
    step();
    step();
    check("post_rst_valid", 32'(thres_valid), 32'(1));
    check("post_rst_thres", 32'(thres),       32'(6'b011010));
    repeat (4) step();

    // Randomized traffic on both paths, checked every cycle by the model.
    rem = 0;
    gap = 0;
    for (int it = 0; it < 800; it++) begin
      if (it == 400) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
      end
      if (rem == 0 && gap == 0) begin
        rem = ($urandom_range(0, 1) == 0) ? W : int'($urandom_range(1, W + 3));
        gap = $urandom_range(1, 3);
      end
      if (rem > 0) begin
        sframe = 1'b1;
        sdi    = 1'($urandom_range(0, 1));
        rem--;
      end else begin
        sframe = 1'b0;
        sdi    = 1'b0;
        gap--;
      end
      vv  = ($urandom_range(0, 4) == 0);
      vin = VW'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      step();
    end
    sframe = 1'b0; sdi = 1'b0; vv = 1'b0; clr = 1'b0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
